mux_sel_scanner: RTL

Time-division select sequencer and sampler that sits directly upstream of the 4:1 mux (mux_4_1), driving its s1/s0 select inputs and capturing its y output. On a start request it visits each enabled input channel in ascending order, holds each select for a programmable dwell time, samples y at the end of the dwell, and delivers the four sampled bits as one word with a single-cycle valid pulse. Typical use: scanning four slow status lines through one mux into a register.

---
 rtl/mux_sel_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mux_sel_scanner.sv
// Select sequencer/sampler for a 4:1 mux: walks enabled channels, dwells, samples y, reports a 4-bit word.
// Optional continuous scanning is enabled by defining SCAN_CONT_EN.
module mux_sel_scanner #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic [3:0] sample,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned CW = 8;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      shadow_q, shadow_d;
    logic [3:0]      sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [3:0]      shadow_y;
    logic [2:0]      first_ch;
    logic [2:0]      next_ch;

    // Lowest set bit of m at index >= from; MSB of the result flags "found".
    function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= from)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'b00;
            cnt_q    <= '0;
            mask_q   <= 4'b0000;
            shadow_q <= 4'b0000;
            sample_q <= 4'b0000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;

        // Shadow word with the currently selected channel's y merged in.
        shadow_y       = shadow_q;
        shadow_y[ch_q] = y;
        first_ch       = pick(mask, 3'd0);
        next_ch        = pick(mask_q, {1'b0, ch_q} + 3'd1);

        case (state_q)
            IDLE: begin
                ch_d   = 2'b00;
                busy_d = 1'b0;
                if (start) begin
                    if (mask != 4'b0000) begin
                        mask_d   = mask;
                        shadow_d = 4'b0000;
                        ch_d     = first_ch[1:0];
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = SCAN;
                    end else begin
                        sample_d = 4'b0000;
                        valid_d  = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d = '0;
                    if (next_ch[2]) begin
                        shadow_d = shadow_y;
                        ch_d     = next_ch[1:0];
                    end else begin
                        sample_d = shadow_y;
                        valid_d  = 1'b1;
`ifdef SCAN_CONT_EN
                        // Re-arm from the live mask; an empty mask ends scanning.
                        if (mask != 4'b0000) begin
                            mask_d   = mask;
                            shadow_d = 4'b0000;
                            ch_d     = first_ch[1:0];
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            ch_d    = 2'b00;
                        end
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ch_d    = 2'b00;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s1     = ch_q[1];
    assign s0     = ch_q[0];
    assign sample = sample_q;
    assign valid  = valid_q;
    assign busy   = busy_q;

endmodule
